// File: rtl/imm_encoder_if.sv
// Handshake and data bundle for imm_encoder: the input word side and the packed output side.
// The master modport is the producer/consumer view; the slave modport is the encoder's view.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] base_instr;
  logic [IMM_WIDTH-1:0]  ImmSrc;
  logic [DATA_WIDTH-1:0] imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] instr_out;
  logic                  imm_err;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    output in_valid, base_instr, ImmSrc, imm, out_ready,
    input  in_ready, out_valid, instr_out, imm_err, err_count
  );

  modport slave (
    input  in_valid, base_instr, ImmSrc, imm, out_ready,
    output in_ready, out_valid, instr_out, imm_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate packer: inserts an immediate into the ImmSrc-specific instruction fields
// and flags unrepresentable immediates. Optional IMM_ENC_STRICT_EN drops errored words instead.
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst,
  imm_encoder_if.slave bus
);

  localparam logic [IMM_WIDTH-1:0] SRC_I = IMM_WIDTH'(0);
  localparam logic [IMM_WIDTH-1:0] SRC_S = IMM_WIDTH'(1);
  localparam logic [IMM_WIDTH-1:0] SRC_B = IMM_WIDTH'(2);
  localparam logic [IMM_WIDTH-1:0] SRC_J = IMM_WIDTH'(3);
  localparam logic [IMM_WIDTH-1:0] SRC_U = IMM_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // stage 1: raw word as accepted
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_base;
  logic [DATA_WIDTH-1:0] s1_imm;
  logic [IMM_WIDTH-1:0]  s1_src;

  // stage 2: packed word as presented
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] instr_out_q;
  logic [CNT_WIDTH-1:0]  err_count_q;

  logic [DATA_WIDTH-1:0] s1_instr;
  logic                  s1_err;
  logic                  adv2;
  logic                  move;
  logic                  load2;
  logic                  accept;
  logic                  out_xfer;
  logic                  cnt_inc;

  function automatic logic all_same(input logic [DATA_WIDTH-1:0] v, input int lsb);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= lsb) begin
        ones  = ones & v[i];
        zeros = zeros & ~v[i];
      end
    end
    return ones | zeros;
  endfunction

  always_comb begin
    s1_instr = s1_base;
    s1_err   = 1'b0;
    case (s1_src)
      SRC_I: begin
        s1_instr[31:20] = s1_imm[11:0];
        s1_err          = !all_same(s1_imm, 11);
      end
      SRC_S: begin
        s1_instr[31:25] = s1_imm[11:5];
        s1_instr[11:7]  = s1_imm[4:0];
        s1_err          = !all_same(s1_imm, 11);
      end
      SRC_B: begin
        s1_instr[31]    = s1_imm[12];
        s1_instr[7]     = s1_imm[11];
        s1_instr[30:25] = s1_imm[10:5];
        s1_instr[11:8]  = s1_imm[4:1];
        s1_err          = !all_same(s1_imm, 12) || s1_imm[0];
      end
      SRC_J: begin
        s1_instr[31]    = s1_imm[20];
        s1_instr[19:12] = s1_imm[19:12];
        s1_instr[20]    = s1_imm[11];
        s1_instr[30:21] = s1_imm[10:1];
        s1_err          = !all_same(s1_imm, 20) || s1_imm[0];
      end
      SRC_U: begin
        s1_instr[31:12] = s1_imm[31:12];
        s1_err          = |s1_imm[11:0];
      end
      default: begin
        s1_err = 1'b1;
      end
    endcase
  end

  assign adv2     = !out_valid_q || bus.out_ready;
  assign move     = s1_valid && adv2;
  assign bus.in_ready = !rst && (!s1_valid || adv2);
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

`ifdef IMM_ENC_STRICT_EN
  // errored words die at the stage boundary; counting happens there since they never reach the output
  assign load2        = move && !s1_err;
  assign cnt_inc      = move && s1_err;
  assign bus.imm_err  = 1'b0;
`else
  logic imm_err_q;

  assign load2        = move;
  assign cnt_inc      = out_xfer && imm_err_q;
  assign bus.imm_err  = imm_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_err_q <= 1'b0;
    end else if (load2) begin
      imm_err_q <= s1_err;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_base     <= '0;
      s1_imm      <= '0;
      s1_src      <= '0;
      out_valid_q <= 1'b0;
      instr_out_q <= '0;
      err_count_q <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_base  <= bus.base_instr;
        s1_imm   <= bus.imm;
        s1_src   <= bus.ImmSrc;
      end else if (move) begin
        s1_valid <= 1'b0;
      end

      if (load2) begin
        out_valid_q <= 1'b1;
        instr_out_q <= s1_instr;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end

      if (cnt_inc && (err_count_q != CNT_MAX)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.instr_out = instr_out_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table for packing/error rules plus hand-written
// back-to-back, backpressure, reset-flush and (with IMM_ENC_STRICT_EN) drop sequences.
module tb_imm_encoder;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;
  vec_t vecs[16];

  imm_encoder_if bus_if ();

  imm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm);
    bus_if.in_valid   = 1'b1;
    bus_if.ImmSrc     = src;
    bus_if.base_instr = base;
    bus_if.imm        = imm;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    drive(v.src, v.base, v.imm);
    #1 check($sformatf("v%0d_in_ready", idx), 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check($sformatf("v%0d_latency1_valid", idx), 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_out_valid", idx), 32'(bus_if.out_valid), 32'd1);
    check($sformatf("v%0d_instr", idx), bus_if.instr_out, v.exp_instr);
    check($sformatf("v%0d_err", idx), 32'(bus_if.imm_err), 32'(v.exp_err));
    if (v.exp_err) exp_cnt++;
    @(negedge clk);
    check($sformatf("v%0d_err_count", idx), 32'(bus_if.err_count), 32'(exp_cnt));
    check($sformatf("v%0d_drained", idx), 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_2023, 32'h0000_07FF, 32'h7E00_2FA3, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000_0063, 32'hFFFF_FFFE, 32'hFE00_0FE3, 1'b0};
    vecs[3]  = '{3'b011, 32'h0000_006F, 32'h0000_0003, 32'h0020_006F, 1'b1};
    vecs[4]  = '{3'b100, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1};
    vecs[5]  = '{3'b100, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0};
    vecs[6]  = '{3'b111, 32'hABCD_E0B3, 32'h0000_0005, 32'hABCD_E0B3, 1'b1};
    vecs[7]  = '{3'b000, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1};
    vecs[8]  = '{3'b000, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
    vecs[9]  = '{3'b010, 32'h0000_0063, 32'h0000_0001, 32'h0000_0063, 1'b1};
    vecs[10] = '{3'b011, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0};
    vecs[11] = '{3'b001, 32'h0000_2023, 32'hFFFF_F800, 32'h8000_2023, 1'b0};
    vecs[12] = '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
    vecs[13] = '{3'b011, 32'h0000_006F, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0};
    vecs[14] = '{3'b100, 32'hFFFF_F037, 32'hABCD_E000, 32'hABCD_E037, 1'b0};
    vecs[15] = '{3'b000, 32'hFFF0_0013, 32'h0000_0000, 32'h0000_0013, 1'b0};

    bus_if.in_valid   = 1'b0;
    bus_if.ImmSrc     = 3'b000;
    bus_if.base_instr = 32'h0;
    bus_if.imm        = 32'h0;
    bus_if.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_instr_out", bus_if.instr_out, 32'd0);
    check("rst_imm_err", 32'(bus_if.imm_err), 32'd0);
    check("rst_err_count", 32'(bus_if.err_count), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(bus_if.in_ready), 32'd1);

`ifdef IMM_ENC_STRICT_EN
    begin
      int n_out;
      n_out = 0;
      @(negedge clk);
      drive(3'b011, 32'h0000_006F, 32'h0000_0003);
      @(posedge clk);
      @(negedge clk);
      drive(3'b000, 32'h0000_0013, 32'h0000_0005);
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (bus_if.out_valid) begin
          n_out++;
          check("strict_instr", bus_if.instr_out, 32'h0050_0013);
          check("strict_imm_err", 32'(bus_if.imm_err), 32'd0);
        end
        @(negedge clk);
      end
      check("strict_words_emitted", 32'(n_out), 32'd1);
      check("strict_err_count", 32'(bus_if.err_count), 32'd1);
    end
`else
    for (int i = 0; i < 16; i++) apply_vec(i);

    // S then B on consecutive cycles
    @(negedge clk);
    drive(3'b001, 32'h0000_2023, 32'h0000_07FF);
    @(posedge clk);
    @(negedge clk);
    drive(3'b010, 32'h0000_0063, 32'hFFFF_FFFE);
    #1 check("b2b_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("b2b_not_yet", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("b2b_s_valid", 32'(bus_if.out_valid), 32'd1);
    check("b2b_s_instr", bus_if.instr_out, 32'h7E00_2FA3);
    @(negedge clk);
    check("b2b_b_valid", 32'(bus_if.out_valid), 32'd1);
    check("b2b_b_instr", bus_if.instr_out, 32'hFE00_0FE3);
    @(negedge clk);
    check("b2b_drained", 32'(bus_if.out_valid), 32'd0);

    // backpressure: two words buffered, third held by the source
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    drive(3'b000, 32'h0000_0013, 32'h0000_0001);
    #1 check("bp_rdy_w1", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(3'b000, 32'h0000_0013, 32'h0000_0002);
    #1 check("bp_rdy_w2", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(3'b000, 32'h0000_0013, 32'h0000_0003);
    #1 check("bp_full_rdy", 32'(bus_if.in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_rdy", 32'(bus_if.in_ready), 32'd0);
      check("bp_stall_valid", 32'(bus_if.out_valid), 32'd1);
      check("bp_stall_instr", bus_if.instr_out, 32'h0010_0013);
    end
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(bus_if.in_ready), 32'd1);
    check("bp_out1", bus_if.instr_out, 32'h0010_0013);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("bp_out2_valid", 32'(bus_if.out_valid), 32'd1);
    check("bp_out2", bus_if.instr_out, 32'h0020_0013);
    @(negedge clk);
    check("bp_out3_valid", 32'(bus_if.out_valid), 32'd1);
    check("bp_out3", bus_if.instr_out, 32'h0030_0013);
    @(negedge clk);
    check("bp_drained", 32'(bus_if.out_valid), 32'd0);
    check("bp_err_count", 32'(bus_if.err_count), 32'(exp_cnt));

    // reset with two errored words in flight
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    drive(3'b011, 32'h0000_006F, 32'h0000_0003);
    @(posedge clk);
    @(negedge clk);
    drive(3'b100, 32'h0000_0037, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("flush_pre_valid", 32'(bus_if.out_valid), 32'd1);
    rst = 1'b1;
    #1 check("flush_rst_rdy", 32'(bus_if.in_ready), 32'd0);
    @(negedge clk);
    check("flush_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("flush_err_count", 32'(bus_if.err_count), 32'd0);
    check("flush_instr", bus_if.instr_out, 32'd0);
    check("flush_imm_err", 32'(bus_if.imm_err), 32'd0);
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(bus_if.out_valid), 32'd0);
    end
    check("flush_final_count", 32'(bus_if.err_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming immediate packer. Inverse of the core's immediate-extension decode.
- Takes a base instruction word (opcode, registers, funct fields), a 32-bit immediate and an ImmSrc type code, and inserts the immediate into the type-specific instruction bit positions.
- Checks that the immediate is representable. Two-stage valid/ready pipeline.
- Used by the boot/program-image loader and by the self-check bench that round-trips immediates through the decode path.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width; only 32 is supported.
- IMM_WIDTH, 3, width of ImmSrc.
- CNT_WIDTH, 16, width of err_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  input accepted on a cycle where in_valid && in_ready.
- base_instr  in  DATA_WIDTH  instruction with non-immediate fields filled.
- ImmSrc  in  IMM_WIDTH  000 I, 001 S, 010 B, 011 J, 100 U; 101..111 illegal.
- imm  in  DATA_WIDTH  immediate value (byte offset for B/J).
- out_valid  out  1  output word present.
- out_ready  in  1  consumer takes word on out_valid && out_ready.
- instr_out  out  DATA_WIDTH  packed instruction.
- imm_err  out  1  qualifies instr_out; immediate not representable or ImmSrc illegal.
- err_count  out  CNT_WIDTH  saturating count of errored words.

Behaviour:
- Reset:
  - out_valid=0, instr_out=0, imm_err=0, err_count=0, stage-1 valid=0.
  - in_ready=0 while rst=1 and 1 in the first cycle after.
  - Reset mid-stream discards all in-flight words; no partial output.
- Pipeline:
  - adv2 = !out_valid || out_ready.
  - Stage 1 moves to stage 2 when s1_valid && adv2.
  - in_ready = !s1_valid || adv2 (combinational).
  - Input accepted at edge N appears at out_valid after edge N+1 (latency 2). Throughput 1 word/cycle when out_ready=1.
  - Stall holds both stages and instr_out/imm_err stable. Order is preserved. Maximum 2 words buffered.
- Packing is done in stage 1. Bits outside the immediate field come from base_instr; immediate-field bits of base_instr are overwritten.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
  - U: [31:12]=imm[31:12].
  - Illegal ImmSrc: instr_out=base_instr unchanged.
- Error checks, computed in stage 1:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - Illegal ImmSrc: error.
  - Errored words are still packed, with truncation.
- Invariant: if imm_err=0, sign-extending instr_out with the same ImmSrc returns imm exactly.
- err_count:
  - Increments by 1 on an output transfer with imm_err=1.
  - Saturates at all-ones (no wrap).
  - Unchanged on stalls.

Optional Feature:
- Macro: IMM_ENC_STRICT_EN.
- Defined:
  - Errored words are dropped at the stage1->stage2 move and never raise out_valid.
  - err_count increments at that drop instead of at output transfer.
  - imm_err is tied 0.
  - Dropping a word frees stage 1 the same cycle.
- Undefined: errored words are emitted with imm_err=1 as in Behaviour.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF, ImmSrc 000, out_ready=1 -> instr_out 0xFFF00013, imm_err 0, out_valid 2 cycles after accept.
- S and B back-to-back:
  - base 0x00002023, imm 0x000007FF, ImmSrc 001 -> 0x7E002FA3.
  - Then base 0x00000063, imm 0xFFFFFFFE, ImmSrc 010 -> 0xFE000FE3.
  - Both on consecutive cycles.
- Errors:
  - J, base 0x0000006F, imm 0x00000003 -> imm_err 1, err_count 1.
  - U, base 0x00000037, imm 0x12345001 -> imm_err 1, err_count 2.
  - U, imm 0x12345000 -> 0x12345037, imm_err 0, err_count stays 2.
- Backpressure:
  - out_ready=0, push 3 I-type words with imm 1, 2, 3 -> in_ready low after 2 accepted; third held by source.
  - Raise out_ready -> outputs in order 1, 2, 3 on consecutive cycles.
  - instr_out stable throughout the stall.
- Illegal and reset:
  - ImmSrc 111, base 0xABCDE0B3 -> instr_out 0xABCDE0B3, imm_err 1.
  - Assert rst with 2 words in flight -> next cycle out_valid 0, err_count 0, no stale word emitted.
- Strict (IMM_ENC_STRICT_EN):
  - Push J with imm 0x3, then I with imm 0x5 -> only the I word emitted, err_count 1, imm_err 0.
